// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared definitions for the data-memory arbiter:
//   - MEM_* command encoding (mirrors the processor's memory command codes)
//   - req_id_t : identifies which requester owns a grant / response
//   - STARVE_W : width of the DBG starvation counter (holds 0..15)
//   - is_store / is_load / misaligned : command classification helpers
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

  localparam logic [3:0] MEM_NONE = 4'd0;
  localparam logic [3:0] MEM_LB   = 4'd1;
  localparam logic [3:0] MEM_LH   = 4'd2;
  localparam logic [3:0] MEM_LW   = 4'd3;
  localparam logic [3:0] MEM_LBU  = 4'd4;
  localparam logic [3:0] MEM_LHU  = 4'd5;
  localparam logic [3:0] MEM_SB   = 4'd6;
  localparam logic [3:0] MEM_SH   = 4'd7;
  localparam logic [3:0] MEM_SW   = 4'd8;

  localparam int STARVE_W = 4;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DBG = 1'b1
  } req_id_t;

  function automatic logic is_store(input logic [3:0] cmd);
    return (cmd == MEM_SB) || (cmd == MEM_SH) || (cmd == MEM_SW);
  endfunction

  // Any command that is neither idle nor a store reads memory.
  function automatic logic is_load(input logic [3:0] cmd);
    return (cmd != MEM_NONE) && !is_store(cmd);
  endfunction

  function automatic logic misaligned(input logic [3:0] cmd, input logic [1:0] addr_lo);
    case (cmd)
      MEM_LH, MEM_LHU, MEM_SH: return addr_lo[0];
      MEM_LW, MEM_SW:          return addr_lo != 2'b00;
      default:                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_arb_stats.sv
// -----------------------------------------------------------------------------
// dmem_arb_stats
// Four saturating event counters for the data-memory arbiter.
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   event_i[3:0]    : one-cycle event strobes {misalign, conflict, dbg_gnt, cpu_gnt}
//   cpu_gnt_o       : number of CPU grants
//   dbg_gnt_o       : number of DBG grants
//   conflict_o      : number of cycles where both sides requested
//   misalign_o      : number of misalignment error pulses
// Counters stop at all-ones instead of wrapping.
// -----------------------------------------------------------------------------
module dmem_arb_stats #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       event_i,
  output logic [CNT_W-1:0] cpu_gnt_o,
  output logic [CNT_W-1:0] dbg_gnt_o,
  output logic [CNT_W-1:0] conflict_o,
  output logic [CNT_W-1:0] misalign_o
);

  logic [CNT_W-1:0] cnt_q [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cnt
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          cnt_q[gi] <= '0;
        end else if (event_i[gi] && (cnt_q[gi] != {CNT_W{1'b1}})) begin
          cnt_q[gi] <= cnt_q[gi] + CNT_W'(1);
        end
      end
    end
  endgenerate

  assign cpu_gnt_o  = cnt_q[0];
  assign dbg_gnt_o  = cnt_q[1];
  assign conflict_o = cnt_q[2];
  assign misalign_o = cnt_q[3];

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares the single data_mem port between the pipeline MEM stage (CPU) and a
// debug / program-loader port (DBG). CPU has fixed priority; DBG is forced a
// grant after STARVE_LIMIT consecutive denied request cycles (1..15).
// Misaligned accesses are granted (so the requester retires them) but never
// issued; they answer with an err pulse one cycle later. Loads return a
// registered word one cycle after the grant, routed to the granted side.
//
// Ports:
//   clk, rst                            : clock, asynchronous active-low reset
//   cpu_req/cmd/addr/wdata (in)         : CPU request, held until cpu_gnt
//   cpu_gnt/rvalid/rdata/err (out)      : CPU grant (comb) and responses (reg)
//   dbg_* (in/out)                      : same as CPU side, for DBG
//   ARB_mem_cmd/addr/din (out)          : command to data_mem, MEM_NONE/0 idle
//   DM_mem_dout (in)                    : combinational read word from data_mem
//   stat_* (out, DMEM_ARB_STATS_EN only): saturating CNT_W-bit event counters
//
// Optional feature macro: DMEM_ARB_STATS_EN (adds stat_* ports and counters).
// -----------------------------------------------------------------------------
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
`ifdef DMEM_ARB_STATS_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic [3:0]  cpu_cmd,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  output logic        cpu_err,
  input  logic        dbg_req,
  input  logic [3:0]  dbg_cmd,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_gnt,
  output logic        dbg_rvalid,
  output logic [31:0] dbg_rdata,
  output logic        dbg_err,
  output logic [3:0]  ARB_mem_cmd,
  output logic [31:0] ARB_mem_addr,
  output logic [31:0] ARB_mem_din,
  input  logic [31:0] DM_mem_dout
`ifdef DMEM_ARB_STATS_EN
  , output logic [CNT_W-1:0] stat_cpu_gnt,
  output logic [CNT_W-1:0] stat_dbg_gnt,
  output logic [CNT_W-1:0] stat_conflict,
  output logic [CNT_W-1:0] stat_misalign
`endif
);

  localparam logic [STARVE_W-1:0] LIMIT_C = STARVE_W'(STARVE_LIMIT);

  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                rvalid_q, rvalid_d;
  logic                err_q, err_d;
  req_id_t             owner_q, owner_d;
  logic [31:0]         cpu_rdata_q, cpu_rdata_d;
  logic [31:0]         dbg_rdata_q, dbg_rdata_d;

  logic        starved;
  logic        cpu_win, dbg_win, any_win, any_gnt;
  logic [3:0]  sel_cmd;
  logic [31:0] sel_addr, sel_wdata;
  logic        sel_mis, sel_load;

  assign starved = (starve_q == LIMIT_C);

  // Arbitration winners, independent of reset; the registers below are held
  // in reset anyway, and only the external grants need masking.
  assign cpu_win = cpu_req && !(dbg_req && starved);
  assign dbg_win = dbg_req && (!cpu_req || starved);
  assign any_win = cpu_win || dbg_win;

  assign cpu_gnt = cpu_win && rst;
  assign dbg_gnt = dbg_win && rst;
  assign any_gnt = cpu_gnt || dbg_gnt;

  assign sel_cmd   = dbg_win ? dbg_cmd   : cpu_cmd;
  assign sel_addr  = dbg_win ? dbg_addr  : cpu_addr;
  assign sel_wdata = dbg_win ? dbg_wdata : cpu_wdata;
  assign sel_mis   = misaligned(sel_cmd, sel_addr[1:0]);
  assign sel_load  = is_load(sel_cmd) && !sel_mis;

  // Misaligned accesses still present addr/din but never a command.
  assign ARB_mem_cmd  = (any_gnt && !sel_mis) ? sel_cmd : MEM_NONE;
  assign ARB_mem_addr = any_gnt ? sel_addr  : 32'd0;
  assign ARB_mem_din  = any_gnt ? sel_wdata : 32'd0;

  always_comb begin
    starve_d    = '0;
    rvalid_d    = any_win && sel_load;
    err_d       = any_win && sel_mis;
    owner_d     = any_win ? (dbg_win ? REQ_DBG : REQ_CPU) : owner_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    // Count denied DBG cycles; a grant or a dropped request restarts the streak.
    if (dbg_req && !dbg_win) begin
      starve_d = starved ? starve_q : starve_q + STARVE_W'(1);
    end
    if (cpu_win && sel_load) cpu_rdata_d = DM_mem_dout;
    if (dbg_win && sel_load) dbg_rdata_d = DM_mem_dout;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q    <= '0;
      rvalid_q    <= 1'b0;
      err_q       <= 1'b0;
      owner_q     <= REQ_CPU;
      cpu_rdata_q <= 32'd0;
      dbg_rdata_q <= 32'd0;
    end else begin
      starve_q    <= starve_d;
      rvalid_q    <= rvalid_d;
      err_q       <= err_d;
      owner_q     <= owner_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  assign cpu_rvalid = rvalid_q && (owner_q == REQ_CPU);
  assign dbg_rvalid = rvalid_q && (owner_q == REQ_DBG);
  assign cpu_err    = err_q && (owner_q == REQ_CPU);
  assign dbg_err    = err_q && (owner_q == REQ_DBG);
  assign cpu_rdata  = cpu_rdata_q;
  assign dbg_rdata  = dbg_rdata_q;

`ifdef DMEM_ARB_STATS_EN
  dmem_arb_stats #(
    .CNT_W(CNT_W)
  ) u_stats (
    .clk       (clk),
    .rst       (rst),
    .event_i   ({err_q, cpu_req && dbg_req, dbg_win, cpu_win}),
    .cpu_gnt_o (stat_cpu_gnt),
    .dbg_gnt_o (stat_dbg_gnt),
    .conflict_o(stat_conflict),
    .misalign_o(stat_misalign)
  );
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Drives directed and randomized traffic into dmem_arbiter, models data_mem,
// and compares every cycle against a behavioural reference of the arbiter.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0, dbg_req = 1'b0;
  logic [3:0]  cpu_cmd = MEM_NONE, dbg_cmd = MEM_NONE;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0, dbg_addr = '0, dbg_wdata = '0;
  logic        cpu_gnt, cpu_rvalid, cpu_err, dbg_gnt, dbg_rvalid, dbg_err;
  logic [31:0] cpu_rdata, dbg_rdata;
  logic [3:0]  ARB_mem_cmd;
  logic [31:0] ARB_mem_addr, ARB_mem_din, DM_mem_dout;
`ifdef DMEM_ARB_STATS_EN
  logic [31:0] stat_cpu_gnt, stat_dbg_gnt, stat_conflict, stat_misalign;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_cmd(cpu_cmd), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .dbg_req(dbg_req), .dbg_cmd(dbg_cmd), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
    .ARB_mem_cmd(ARB_mem_cmd), .ARB_mem_addr(ARB_mem_addr), .ARB_mem_din(ARB_mem_din),
    .DM_mem_dout(DM_mem_dout)
`ifdef DMEM_ARB_STATS_EN
    , .stat_cpu_gnt(stat_cpu_gnt), .stat_dbg_gnt(stat_dbg_gnt),
    .stat_conflict(stat_conflict), .stat_misalign(stat_misalign)
`endif
  );

  // ---------------- comparison helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory semantics shared by data_mem and the reference ----------------
  function automatic int access_size(input logic [3:0] cmd);
    case (cmd)
      MEM_LB, MEM_LBU, MEM_SB: return 1;
      MEM_LH, MEM_LHU, MEM_SH: return 2;
      MEM_LW, MEM_SW:          return 4;
      default:                 return 0;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] cmd,
                                        input logic [1:0] off, input logic [31:0] d);
    logic [31:0] r;
    int sz, base;
    r = old;
    sz = access_size(cmd);
    base = int'(off) - (int'(off) % sz);
    for (int k = 0; k < sz; k++) r[8*(base+k) +: 8] = d[8*k +: 8];
    return r;
  endfunction

  // data_mem stand-in: combinational read, write at the clock edge
  logic [31:0] mem [64] = '{default: 32'd0};
  assign DM_mem_dout = mem[ARB_mem_addr[7:2]];
  always @(posedge clk) begin
    if (ARB_mem_cmd == MEM_SB || ARB_mem_cmd == MEM_SH || ARB_mem_cmd == MEM_SW)
      mem[ARB_mem_addr[7:2]] <= merge(mem[ARB_mem_addr[7:2]], ARB_mem_cmd,
                                      ARB_mem_addr[1:0], ARB_mem_din);
  end

  // ---------------- behavioural reference + per-cycle compare ----------------
  logic [31:0] ref_mem [64] = '{default: 32'd0};
  int          wait_streak = 0;      // consecutive cycles DBG has been refused
  logic        e_cv = 0, e_ce = 0, e_dv = 0, e_de = 0;
  logic [31:0] e_cd = 0, e_dd = 0;
  logic        cpu_seen = 0, dbg_seen = 0;
  longint      m_cg = 0, m_dg = 0, m_cf = 0, m_mis = 0;

  always @(negedge clk) begin
    logic dbg_turn, g_c, g_d, g_any, mis, st, ld;
    logic [3:0] g_cmd;
    logic [31:0] g_addr, g_data;
    int sz;
    if (!rst) begin
      chk("rst_cpu_gnt", {31'd0, cpu_gnt}, 0);
      chk("rst_dbg_gnt", {31'd0, dbg_gnt}, 0);
      chk("rst_cmd", {28'd0, ARB_mem_cmd}, {28'd0, MEM_NONE});
      chk("rst_resp", {28'd0, cpu_rvalid, cpu_err, dbg_rvalid, dbg_err}, 0);
      chk("rst_rdata", cpu_rdata | dbg_rdata, 0);
      wait_streak = 0;
      e_cv = 0; e_ce = 0; e_dv = 0; e_de = 0; e_cd = 0; e_dd = 0;
      cpu_seen = 0; dbg_seen = 0;
      m_cg = 0; m_dg = 0; m_cf = 0; m_mis = 0;
`ifdef DMEM_ARB_STATS_EN
      chk("rst_stats", stat_cpu_gnt | stat_dbg_gnt | stat_conflict | stat_misalign, 0);
`endif
    end else begin
      // DBG wins when CPU is silent or DBG has already waited LIMIT cycles.
      dbg_turn = dbg_req && (!cpu_req || wait_streak >= LIMIT);
      g_d = dbg_turn;
      g_c = cpu_req && !dbg_turn;
      g_any = g_c || g_d;
      g_cmd  = g_d ? dbg_cmd   : cpu_cmd;
      g_addr = g_d ? dbg_addr  : cpu_addr;
      g_data = g_d ? dbg_wdata : cpu_wdata;
      sz  = access_size(g_cmd);
      mis = g_any && sz > 1 && (int'(g_addr[1:0]) % sz) != 0;
      st  = (g_cmd == MEM_SB || g_cmd == MEM_SH || g_cmd == MEM_SW);
      ld  = g_any && !st && g_cmd != MEM_NONE && !mis;

      chk("cpu_gnt", {31'd0, cpu_gnt}, {31'd0, g_c});
      chk("dbg_gnt", {31'd0, dbg_gnt}, {31'd0, g_d});
      chk("mem_cmd", {28'd0, ARB_mem_cmd}, {28'd0, (g_any && !mis) ? g_cmd : MEM_NONE});
      chk("mem_addr", ARB_mem_addr, g_any ? g_addr : 32'd0);
      chk("mem_din", ARB_mem_din, g_any ? g_data : 32'd0);
      chk("cpu_rvalid", {31'd0, cpu_rvalid}, {31'd0, e_cv});
      chk("cpu_err", {31'd0, cpu_err}, {31'd0, e_ce});
      chk("cpu_rdata", cpu_rdata, e_cd);
      chk("dbg_rvalid", {31'd0, dbg_rvalid}, {31'd0, e_dv});
      chk("dbg_err", {31'd0, dbg_err}, {31'd0, e_de});
      chk("dbg_rdata", dbg_rdata, e_dd);
`ifdef DMEM_ARB_STATS_EN
      chk("stat_cpu_gnt", stat_cpu_gnt, 32'(m_cg));
      chk("stat_dbg_gnt", stat_dbg_gnt, 32'(m_dg));
      chk("stat_conflict", stat_conflict, 32'(m_cf));
      chk("stat_misalign", stat_misalign, 32'(m_mis));
`endif
      // Advance the reference to what the next cycle must show.
      m_cg += longint'(g_c);
      m_dg += longint'(g_d);
      m_cf += longint'(cpu_req && dbg_req);
      m_mis += longint'(e_ce || e_de);
      e_cv = g_c && ld;  e_ce = g_c && mis;
      e_dv = g_d && ld;  e_de = g_d && mis;
      if (g_c && ld) e_cd = ref_mem[g_addr[7:2]];
      if (g_d && ld) e_dd = ref_mem[g_addr[7:2]];
      if (g_any && st && !mis)
        ref_mem[g_addr[7:2]] = merge(ref_mem[g_addr[7:2]], g_cmd, g_addr[1:0], g_data);
      if (dbg_req && !g_d) wait_streak = (wait_streak < LIMIT) ? wait_streak + 1 : LIMIT;
      else wait_streak = 0;
      cpu_seen = g_c;
      dbg_seen = g_d;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cpu(input logic r, input logic [3:0] c, input logic [31:0] a, input logic [31:0] d);
    cpu_req = r; cpu_cmd = c; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic set_dbg(input logic r, input logic [3:0] c, input logic [31:0] a, input logic [31:0] d);
    dbg_req = r; dbg_cmd = c; dbg_addr = a; dbg_wdata = d;
  endtask

  function automatic logic [3:0] rand_cmd();
    logic [3:0] tbl [9];
    tbl = '{MEM_NONE, MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW};
    return tbl[$urandom_range(0, 8)];
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = 32'($urandom_range(0, 255));
    if ($urandom_range(0, 9) < 6) a[1:0] = 2'b00;
    return a;
  endfunction

  logic [9:0] cpat, dpat;

  initial begin
    #2 rst = 1'b0;
    // Reset then idle
    repeat (3) @(negedge clk);
    chk("lit_rst_cmd", {28'd0, ARB_mem_cmd}, {28'd0, MEM_NONE});
    tick(); rst = 1'b1;
    @(negedge clk);
    chk("lit_idle_outs", {28'd0, cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid}, 0);

    // CPU store then load of the same word
    tick(); set_cpu(1, MEM_SW, 32'h10, 32'hDEADBEEF);
    @(negedge clk);
    chk("lit_sw_gnt", {31'd0, cpu_gnt}, 1);
    chk("lit_sw_cmd", {28'd0, ARB_mem_cmd}, {28'd0, MEM_SW});
    tick(); set_cpu(1, MEM_LW, 32'h10, 32'h0);
    @(negedge clk);
    chk("lit_lw_gnt", {31'd0, cpu_gnt}, 1);
    tick(); set_cpu(0, MEM_NONE, 0, 0);
    @(negedge clk);
    chk("lit_lw_rvalid", {31'd0, cpu_rvalid}, 1);
    chk("lit_lw_rdata", cpu_rdata, 32'hDEADBEEF);

    // Continuous conflict from a fresh reset
    tick(); rst = 1'b0;
    tick(); rst = 1'b1;
    tick();
    set_cpu(1, MEM_SW, 32'h0, 32'hA5A5A5A5);
    set_dbg(1, MEM_SW, 32'h4, 32'h5A5A5A5A);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      cpat[i] = cpu_gnt;
      dpat[i] = dbg_gnt;
    end
    chk("lit_conflict_cpu", {22'd0, cpat}, 32'h1EF);
    chk("lit_conflict_dbg", {22'd0, dpat}, 32'h210);
    tick(); set_cpu(0, MEM_NONE, 0, 0); set_dbg(0, MEM_NONE, 0, 0);
    @(negedge clk);
`ifdef DMEM_ARB_STATS_EN
    chk("lit_stat_cpu", stat_cpu_gnt, 8);
    chk("lit_stat_dbg", stat_dbg_gnt, 2);
    chk("lit_stat_conflict", stat_conflict, 10);
    chk("lit_stat_misalign", stat_misalign, 0);
`endif

    // DBG alone: store then load at 0x20
    tick(); set_dbg(1, MEM_SW, 32'h20, 32'h12345678);
    tick(); set_dbg(1, MEM_LW, 32'h20, 32'h0);
    @(negedge clk);
    chk("lit_dbg_gnt", {30'd0, cpu_gnt, dbg_gnt}, 1);
    tick(); set_dbg(0, MEM_NONE, 0, 0);
    @(negedge clk);
    chk("lit_dbg_rvalid", {30'd0, cpu_rvalid, dbg_rvalid}, 1);
    chk("lit_dbg_rdata", dbg_rdata, 32'h12345678);

    // Misaligned halfword store and word load
    tick(); set_cpu(1, MEM_SH, 32'h3, 32'h0000BEEF);
    @(negedge clk);
    chk("lit_sh_mis_gnt", {31'd0, cpu_gnt}, 1);
    chk("lit_sh_mis_cmd", {28'd0, ARB_mem_cmd}, {28'd0, MEM_NONE});
    tick(); set_cpu(1, MEM_LW, 32'h2, 32'h0);
    @(negedge clk);
    chk("lit_sh_err", {31'd0, cpu_err}, 1);
    chk("lit_sh_mem", mem[0], 32'hA5A5A5A5);
    tick(); set_cpu(0, MEM_NONE, 0, 0);
    @(negedge clk);
    chk("lit_lw_mis", {30'd0, cpu_err, cpu_rvalid}, 2);

    // Reset while a load response is pending
    tick(); set_cpu(1, MEM_LW, 32'h10, 32'h0);
    @(negedge clk);
    tick(); set_cpu(0, MEM_NONE, 0, 0); rst = 1'b0;
    @(negedge clk);
    chk("lit_rst_mid_rvalid", {31'd0, cpu_rvalid}, 0);
    tick(); rst = 1'b1;
    @(negedge clk);
    chk("lit_rst_after_rvalid", {31'd0, cpu_rvalid}, 0);

    // Randomized traffic, with held requests, drops and occasional resets
    for (int n = 0; n < 3000; n++) begin
      tick();
      rst = ($urandom_range(0, 299) != 0);
      if (!cpu_req || cpu_seen) begin
        if ($urandom_range(0, 9) < 7) set_cpu(1, rand_cmd(), rand_addr(), $urandom);
        else set_cpu(0, MEM_NONE, 0, 0);
      end else if ($urandom_range(0, 19) == 0) begin
        set_cpu(0, MEM_NONE, 0, 0);
      end
      if (!dbg_req || dbg_seen) begin
        if ($urandom_range(0, 9) < 6) set_dbg(1, rand_cmd(), rand_addr(), $urandom);
        else set_dbg(0, MEM_NONE, 0, 0);
      end else if ($urandom_range(0, 19) == 0) begin
        set_dbg(0, MEM_NONE, 0, 0);
      end
    end

    tick(); rst = 1'b1; set_cpu(0, MEM_NONE, 0, 0); set_dbg(0, MEM_NONE, 0, 0);
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data_mem command/address/data port between two requesters: the pipeline MEM stage (CPU port) and a debug/program-loader port (DBG port).
- Fixed priority to CPU with a starvation guard for DBG.
- Alignment check on every access; misaligned accesses are never issued.
- Read data is captured and returned one cycle after grant, tagged to the granted requester.

Parameters:
- STARVE_LIMIT, 4, consecutive denied DBG request cycles before DBG is forced a grant; legal range 1..15.
- CNT_W, 32, width of statistics counters (used only with DMEM_ARB_STATS_EN).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request, level, held until cpu_gnt
- cpu_cmd  in  4  `MEM_* command from sys_defs.vh
- cpu_addr  in  32  byte address
- cpu_wdata  in  32  store data, LSB-aligned
- cpu_gnt  out  1  access issued this cycle (combinational)
- cpu_rvalid  out  1  read data valid, one cycle after a load grant
- cpu_rdata  out  32  registered read word
- cpu_err  out  1  misaligned pulse, one cycle after request sampled
- dbg_req, dbg_cmd, dbg_addr, dbg_wdata  in  1/4/32/32  same semantics as CPU side
- dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err  out  1/1/32/1  same semantics as CPU side
- ARB_mem_cmd  out  4  to data_mem; `MEM_NONE when idle
- ARB_mem_addr  out  32  to data_mem
- ARB_mem_din  out  32  to data_mem
- DM_mem_dout  in  32  combinational read word from data_mem

Behaviour:
- Reset (rst low, async): starve_cnt=0; all rvalid/err/rdata registers=0; ARB_mem_cmd=`MEM_NONE, addr/din=0. gnt outputs are 0 while rst is low.
- Classification: store = `MEM_SB/`MEM_SH/`MEM_SW; load = any other non-`MEM_NONE command.
- Misaligned: SH/LH with addr[0]=1; SW/LW with addr[1:0]!=0.
- Misaligned request: receives gnt (so the requester retires it), but ARB_mem_cmd stays `MEM_NONE. err pulses 1 cycle later; no rvalid follows.
- Grant, evaluated combinationally each cycle:
  - Only CPU requests: CPU granted.
  - Only DBG requests: DBG granted.
  - Both request and starve_cnt < STARVE_LIMIT: CPU granted.
  - Both request and starve_cnt == STARVE_LIMIT: DBG granted.
- At most one gnt is high per cycle.
- starve_cnt:
  - Increments when dbg_req=1 and dbg_gnt=0, saturating at STARVE_LIMIT.
  - Clears on dbg_gnt or when dbg_req=0.
- Mux: ARB_mem_* carry the granted requester's cmd/addr/wdata; `MEM_NONE/0 with no grant.
- Load response: at the grant edge, rdata_q <= DM_mem_dout and owner_q <= granted id. The matching rvalid is 1 the next cycle; the other side's rdata holds its previous value.
- Latency: store visible in memory after the grant edge. A load issued in cycle N returns in cycle N+1. Back-to-back grants are allowed every cycle.
- Dropped requests: if a requester drops req without gnt, the request is discarded silently.
- Reset mid-operation: a pending rvalid/err is cleared; no response is produced after reset.

Optional Feature:
Macro DMEM_ARB_STATS_EN.
- Defined: adds outputs stat_cpu_gnt, stat_dbg_gnt, stat_conflict, stat_misalign, each CNT_W wide.
  - stat_cpu_gnt / stat_dbg_gnt count grants.
  - stat_conflict counts cycles with both requests.
  - stat_misalign counts err events.
  - All counters saturate at all-ones and reset to 0.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package dmem_arb_pkg holds:
  - enum req_id_t {REQ_CPU=0, REQ_DBG=1};
  - STARVE_W = 4;
  - functions is_store(cmd), is_load(cmd) and misaligned(cmd, addr[1:0]), built on `MEM_* macros from sys_defs.vh.
- Sub-module dmem_arb_stats holds the four saturating counters, instantiated only under DMEM_ARB_STATS_EN.

Test Plan:
- Reset then idle: all outputs 0, ARB_mem_cmd=`MEM_NONE. Assert rst low mid-load → rvalid stays 0.
- CPU SW addr 0x10 data 0xDEADBEEF, next cycle CPU LW 0x10 → cpu_gnt both cycles; cpu_rvalid=1 with cpu_rdata=0xDEADBEEF one cycle after the load grant.
- Both requesting continuously with STARVE_LIMIT=4 → CPU granted cycles 0-3, DBG granted cycle 4, CPU cycles 5-8, DBG cycle 9.
- DBG LW 0x20 alone while CPU idle → dbg_gnt same cycle; dbg_rvalid next cycle; cpu_rvalid stays 0.
- CPU SH addr 0x3 → cpu_gnt=1, ARB_mem_cmd=`MEM_NONE, cpu_err=1 next cycle, memory unchanged. CPU LW 0x2 → cpu_err, no rvalid.
- With DMEM_ARB_STATS_EN: run the 10-cycle conflict test → stat_cpu_gnt=8, stat_dbg_gnt=2, stat_conflict=10, stat_misalign=0.
